// File: rtl/branch_dir_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch direction predictor.
// Includes the 2-bit saturating counter encoding, the per-stage prediction record and the train-step helper.
package branch_dir_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [31:0] pc;
    } pred_pipe_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != CNT_ST) r = c + 2'd1;
        end else begin
            if (c != CNT_SNT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_dir_predictor_sat_counter_table.sv
// Table of 2-bit saturating direction counters: one async read port, one synchronous train port.
// A read of the entry being trained in the same cycle returns the pre-update value.
module sat_counter_table
    import branch_dir_predictor_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             tr_en,
    input  logic [IDX_W-1:0] tr_idx,
    input  logic             tr_taken
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] ctr_d [DEPTH];

    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (tr_en) ctr_d[tr_idx] = sat_step(ctr_q[tr_idx], tr_taken);
    end

    always_ff @(posedge clk) begin
        if (reset) ctr_q <= '{default: CNT_INIT};
        else       ctr_q <= ctr_d;
    end

endmodule

// File: rtl/branch_dir_predictor.sv
// Fetch-stage direction predictor: combines BTB hit with counters, tracks the prediction
// through F/D and D/E, resolves it in Execute, trains the counters and counts mispredicts.
module branch_dir_predictor
    import branch_dir_predictor_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01,
    parameter int unsigned PERF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pcF,
    input  logic              btbHit,
    input  logic [31:0]       btbBTA,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic              branchE,
    input  logic              branchTakenE,
    input  logic [31:0]       aluBranchAddress,
    output logic              predictTakenF,
    output logic [31:0]       pcNextPredF,
    output logic              branchPredictedE,
    output logic              mispredictE,
    output logic [31:0]       pcCorrectE,
    output logic [PERF_W-1:0] mispredCount
);

    pred_pipe_t        fd_q, fd_d;
    pred_pipe_t        de_q, de_d;
    logic [PERF_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [1:0]        ctr_f;
    logic              train_en;

    sat_counter_table #(
        .IDX_W   (IDX_W),
        .CNT_INIT(CNT_INIT)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (pcF[IDX_W+1:2]),
        .rd_ctr  (ctr_f),
        .tr_en   (train_en),
        .tr_idx  (de_q.pc[IDX_W+1:2]),
        .tr_taken(branchTakenE)
    );

    assign predictTakenF    = btbHit & ctr_f[1];
    assign pcNextPredF      = predictTakenF ? btbBTA : pcF + PC_STEP;
    assign branchPredictedE = de_q.valid & de_q.pred;
    // Second term catches a BTB alias: a taken prediction on a non-branch.
    assign mispredictE      = de_q.valid & ((branchE & (branchTakenE != de_q.pred)) | (~branchE & de_q.pred));
    assign pcCorrectE       = (branchE & branchTakenE) ? aluBranchAddress : de_q.pc + PC_STEP;
    assign train_en         = de_q.valid & branchE;
    assign mispredCount     = mis_cnt_q;

    always_comb begin
        fd_d = fd_q;
        if (flushD)      fd_d = '0;
        else if (!stallD) fd_d = '{valid: 1'b1, pred: predictTakenF, pc: pcF};

        de_d = flushE ? '0 : fd_q;

        mis_cnt_d = mis_cnt_q;
        if (mispredictE && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_q      <= '0;
            de_q      <= '0;
            mis_cnt_q <= '0;
        end else begin
            fd_q      <= fd_d;
            de_q      <= de_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_dir_predictor.sv
// Bench for branch_dir_predictor: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of counters and prediction pipeline.
module tb_branch_dir_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF, btbBTA, aluBranchAddress;
    logic        btbHit, stallD, flushD, flushE, branchE, branchTakenE;

    logic        predictTakenF, branchPredictedE, mispredictE;
    logic [31:0] pcNextPredF, pcCorrectE;
    logic [15:0] mispredCount;

    logic        s_predictTakenF, s_branchPredictedE, s_mispredictE;
    logic [31:0] s_pcNextPredF, s_pcCorrectE;
    logic [1:0]  s_mispredCount;

    int total = 0;
    int bad   = 0;

    branch_dir_predictor #(.IDX_W(4), .CNT_INIT(2'b01), .PERF_W(16)) dut (
        .clk(clk), .reset(reset), .pcF(pcF), .btbHit(btbHit), .btbBTA(btbBTA),
        .stallD(stallD), .flushD(flushD), .flushE(flushE), .branchE(branchE),
        .branchTakenE(branchTakenE), .aluBranchAddress(aluBranchAddress),
        .predictTakenF(predictTakenF), .pcNextPredF(pcNextPredF),
        .branchPredictedE(branchPredictedE), .mispredictE(mispredictE),
        .pcCorrectE(pcCorrectE), .mispredCount(mispredCount)
    );

    branch_dir_predictor #(.IDX_W(4), .CNT_INIT(2'b01), .PERF_W(2)) dut_sat (
        .clk(clk), .reset(reset), .pcF(pcF), .btbHit(btbHit), .btbBTA(btbBTA),
        .stallD(stallD), .flushD(flushD), .flushE(flushE), .branchE(branchE),
        .branchTakenE(branchTakenE), .aluBranchAddress(aluBranchAddress),
        .predictTakenF(s_predictTakenF), .pcNextPredF(s_pcNextPredF),
        .branchPredictedE(s_branchPredictedE), .mispredictE(s_mispredictE),
        .pcCorrectE(s_pcCorrectE), .mispredCount(s_mispredCount)
    );

    always #5 clk = ~clk;

    // Hazard-unit contract: a stalled decode must be accompanied by an execute flush.
    always @(posedge clk) begin
        if (!reset && stallD && !flushE) $error("stallD asserted without flushE");
    end

    // Behavioural model: counters as plain integers, pipeline as two records.
    int          m_ctr [16];
    bit          m_fd_v, m_fd_p, m_de_v, m_de_p;
    logic [31:0] m_fd_pc, m_de_pc;
    longint      m_cnt;
    bit          m_init = 0;

    function automatic bit m_pred();
        return btbHit && (m_ctr[pcF[5:2]] >= 2);
    endfunction

    function automatic bit m_mis();
        if (!m_de_v) return 0;
        return branchE ? (branchTakenE != m_de_p) : m_de_p;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] nxt, corr;
        longint      c16, c2;
        if (!m_init) return;
        nxt  = m_pred() ? btbBTA : pcF + 32'd4;
        corr = (branchE && branchTakenE) ? aluBranchAddress : m_de_pc + 32'd4;
        c16  = (m_cnt > 65535) ? 65535 : m_cnt;
        c2   = (m_cnt > 3) ? 3 : m_cnt;
        chk("predictTakenF",    predictTakenF,    m_pred());
        chk("pcNextPredF",      pcNextPredF,      nxt);
        chk("branchPredictedE", branchPredictedE, m_de_v && m_de_p);
        chk("mispredictE",      mispredictE,      m_mis());
        if (m_mis()) chk("pcCorrectE", pcCorrectE, corr);
        chk("mispredCount",     mispredCount,     c16);
        chk("sat_mispredCount", s_mispredCount,   c2);
        chk("sat_pcNextPredF",  s_pcNextPredF,    nxt);
        chk("sat_mispredictE",  s_mispredictE,    m_mis());
    endtask

    task automatic model_update();
        bit pred, mis;
        if (reset) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            {m_fd_v, m_fd_p, m_fd_pc} = '0;
            {m_de_v, m_de_p, m_de_pc} = '0;
            m_cnt  = 0;
            m_init = 1;
            return;
        end
        pred = m_pred();
        mis  = m_mis();
        if (m_de_v && branchE) begin
            if (branchTakenE) m_ctr[m_de_pc[5:2]] = (m_ctr[m_de_pc[5:2]] == 3) ? 3 : m_ctr[m_de_pc[5:2]] + 1;
            else              m_ctr[m_de_pc[5:2]] = (m_ctr[m_de_pc[5:2]] == 0) ? 0 : m_ctr[m_de_pc[5:2]] - 1;
        end
        if (mis) m_cnt++;
        if (flushE) {m_de_v, m_de_p, m_de_pc} = '0;
        else        {m_de_v, m_de_p, m_de_pc} = {m_fd_v, m_fd_p, m_fd_pc};
        if (flushD)       {m_fd_v, m_fd_p, m_fd_pc} = '0;
        else if (!stallD) {m_fd_v, m_fd_p, m_fd_pc} = {1'b1, pred, pcF};
    endtask

    // Drive at the falling edge, check after settling, model advances on the rising edge.
    task automatic drive(input logic [31:0] pc, input bit hit, input logic [31:0] bta,
                         input bit st, input bit fd, input bit fe,
                         input bit br, input bit tk, input logic [31:0] alu, input bit rst);
        pcF = pc; btbHit = hit; btbBTA = bta; stallD = st; flushD = fd; flushE = fe;
        branchE = br; branchTakenE = tk; aluBranchAddress = alu; reset = rst;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1); tick();

        // c0: reset state
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 32'h40, 0);
        chk("rst_pred", predictTakenF, 0);
        chk("rst_next", pcNextPredF, 32'h14);
        chk("rst_cnt", mispredCount, 0);
        chk("rst_corr", pcCorrectE, 32'h4);
        chk("rst_bpE", branchPredictedE, 0);
        tick();
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 32'h40, 0); tick();           // c1
        drive(32'h10, 1, 32'h40, 0, 0, 0, 1, 1, 32'h40, 0);                   // c2 train 1->2
        chk("c2_mis", mispredictE, 1);
        chk("c2_corr", pcCorrectE, 32'h40);
        chk("c2_pred_collide", predictTakenF, 0);
        tick();
        drive(32'h10, 1, 32'h40, 0, 0, 0, 1, 1, 32'h40, 0);                   // c3 train 2->3
        chk("c3_pred", predictTakenF, 1);
        chk("c3_next", pcNextPredF, 32'h40);
        tick();
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 32'h40, 0); tick();           // c4
        drive(32'h10, 1, 32'h40, 0, 0, 0, 1, 0, 32'h40, 0);                   // c5 3->2
        chk("c5_bpE", branchPredictedE, 1);
        chk("c5_mis", mispredictE, 1);
        chk("c5_corr", pcCorrectE, 32'h14);
        tick();
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 32'h40, 0);                   // c6 alias
        chk("alias_mis", mispredictE, 1);
        chk("alias_corr", pcCorrectE, 32'h14);
        tick();
        drive(32'h10, 1, 32'h40, 0, 0, 0, 0, 0, 32'h40, 0);                   // c7 alias again
        chk("c7_pred_ctr2", predictTakenF, 1);
        tick();
        drive(32'h20, 0, 32'h0, 1, 0, 1, 1, 1, 32'h80, 0);                    // stall+flushE
        chk("cnt5", mispredCount, 5);
        chk("sat_cnt3", s_mispredCount, 3);
        tick();
        drive(32'h20, 0, 32'h0, 1, 0, 1, 1, 1, 32'h80, 0);
        chk("stall_validE", branchPredictedE, 0);
        chk("stall_mis", mispredictE, 0);
        tick();
        drive(32'h20, 0, 32'h0, 1, 1, 1, 1, 1, 32'h80, 0); tick();            // flushD wins
        drive(32'h24, 0, 32'h0, 0, 0, 0, 1, 1, 32'h80, 0); tick();
        drive(32'hFFFFFFFC, 0, 32'h0, 0, 0, 0, 1, 1, 32'h80, 0);
        chk("flushD_validE", mispredictE, 0);
        chk("wrap_next", pcNextPredF, 32'h0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, bta, alu;
            bit st, fd, fe, rst;
            pc  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 15)) * 4;
            bta = $urandom & 32'hFFFF_FFFC;
            alu = $urandom & 32'hFFFF_FFFC;
            st  = ($urandom_range(0, 9) == 0);
            fd  = ($urandom_range(0, 9) == 0);
            fe  = st || ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            drive(pc, $urandom_range(0, 9) < 7, bta, st, fd, fe,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, alu, rst);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_dir_predictor.md
Name: branch_dir_predictor

Overview:
- Direction predictor and prediction tracker in the fetch stage, next to the branch target buffer.
- Combines the BTB hit/target with a table of 2-bit saturating counters to choose the predicted next PC.
- Carries each prediction through the F/D and D/E stages.
- In Execute it resolves the branch. It produces the mispredict flush and corrected PC, supplies branchPredictedE back to the BTB, and trains the counters.

Parameters:
- IDX_W, 4, counter-table index width; table depth = 2**IDX_W; index = pc[IDX_W+1:2].
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken).
- PERF_W, 16, width of the saturating mispredict statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pcF  in  32  current fetch PC.
- btbHit  in  1  BTB hit for pcF.
- btbBTA  in  32  BTB target for pcF.
- stallD  in  1  hold the F/D prediction register.
- flushD  in  1  clear the F/D prediction register.
- flushE  in  1  clear the D/E prediction register.
- branchE  in  1  instruction in Execute is a conditional branch.
- branchTakenE  in  1  resolved direction in Execute.
- aluBranchAddress  in  32  resolved branch target in Execute.
- predictTakenF  out  1  fetch-stage taken prediction.
- pcNextPredF  out  32  predicted next fetch PC.
- branchPredictedE  out  1  prediction carried to Execute; goes to the BTB.
- mispredictE  out  1  redirect request; flushes D and E upstream.
- pcCorrectE  out  32  redirect PC, valid when mispredictE = 1.
- mispredCount  out  PERF_W  saturating count of mispredictions.

Behaviour:
- Fetch stage, combinational:
  - idxF = pcF[IDX_W+1:2].
  - predictTakenF = btbHit & ctr[idxF][1].
  - pcNextPredF = predictTakenF ? btbBTA : pcF + 4. Addition is mod 2^32; 0xFFFFFFFC + 4 wraps to 0.
- F/D register {validD, predD, pcD}:
  - On reset or flushD: all fields 0.
  - Else on stallD: hold.
  - Else: capture {1, predictTakenF, pcF}.
  - flushD has priority over stallD.
- D/E register {validE, predE, pcE}:
  - On reset or flushE: all fields 0.
  - Else: capture the F/D contents every cycle.
  - When stallD = 1 and flushE = 0, the D/E register still loads from F/D, which duplicates the held entry in E. The hazard unit must assert flushE with stallD; benches check this pairing with an assertion.
- Execute resolution, combinational, qualified by validE:
  - branchPredictedE = validE & predE.
  - mispredictE = validE & ((branchE & (branchTakenE != predE)) | (~branchE & predE)).
  - The second term covers a BTB alias: predicted taken on a non-branch.
  - pcCorrectE = (branchE & branchTakenE) ? aluBranchAddress : pcE + 4.
- Counter training, on the clock edge when validE & branchE:
  - idxE = pcE[IDX_W+1:2].
  - Taken: ctr[idxE] = min(ctr + 1, 3). Not taken: ctr[idxE] = max(ctr - 1, 0).
  - Non-branches never train.
- Read/write collision (idxF == idxE in the same cycle): the F read returns the pre-update value. There is no bypass.
- mispredCount:
  - Increments on each clock edge where mispredictE = 1.
  - Saturates at 2**PERF_W - 1.
- Reset, synchronous:
  - All counters set to CNT_INIT; validD = validE = 0; mispredCount = 0.
  - Resulting outputs: predictTakenF = 0 (counter bit1 = 0), pcNextPredF = pcF + 4, branchPredictedE = 0, mispredictE = 0, pcCorrectE = 4 (pcE = 0).
  - Reset asserted mid-operation discards in-flight predictions. No counter update happens on a cycle where reset = 1.
- Latency:
  - Prediction is zero-cycle in F.
  - Resolution happens 2 cycles later in E.
  - A counter update is visible to fetch on the cycle after the edge that writes it.

Decomposition:
- Shared package:
  - Constants CNT_SNT = 0, CNT_WNT = 1, CNT_WT = 2, CNT_ST = 3.
  - Typedef pred_pipe_t {valid, pred, pc[31:0]}.
  - PC_STEP = 4.
- One sub-module, sat_counter_table: IDX_W-indexed 2-bit counters, one async read port, one synchronous train port (en, idx, taken), sync reset to CNT_INIT.
- Pipeline registers and resolution logic stay in the top module.

Test Plan:
- Reset: after reset, pcF = 0x10, btbHit = 1, btbBTA = 0x40 -> predictTakenF = 0, pcNextPredF = 0x14, mispredCount = 0.
- Training: branch at pc 0x10 resolved taken twice (branchE = 1, branchTakenE = 1) -> ctr[4] goes 1→2→3; next fetch of 0x10 with btbHit = 1, btbBTA = 0x40 -> predictTakenF = 1, pcNextPredF = 0x40.
- Mispredict: predicted taken at 0x10, E resolves not-taken -> mispredictE = 1, pcCorrectE = 0x14, mispredCount += 1, ctr[4] 3→2.
- Alias: predE = 1 on a non-branch at pcE = 0x20 -> mispredictE = 1, pcCorrectE = 0x24, no counter change.
- Hazards: stallD = 1 with flushE = 1 for 2 cycles -> F/D holds, validE = 0, no training. flushD and stallD together -> validD = 0.
- Saturation and wrap: PERF_W = 2, force 5 mispredicts -> mispredCount = 3. pcF = 0xFFFFFFFC, no hit -> pcNextPredF = 0x0.
